interleaved_load_reg: RTL and testbench
=======================================

Name: interleaved_load_reg

Overview:
- Parametrised successor to the timer's byte-interleaved load register.
- Builds an 8*NBYTES-bit value from an 8-bit bus into a shadow register, then commits it atomically to the active output, so timer compare/reload logic never sees a half-written value.
- Supports two load modes: indexed (byte lane chosen per write) and sequential (internal byte pointer, auto-increment).
- Sits between the MCU peripheral write bus and the timer counter/compare datapath.

Parameters:
- NBYTES, 4: number of byte lanes; legal range 2..8.
- AUTO_COMMIT, 1: 1 = commit automatically on a write to lane NBYTES-1; 0 = commit only on the commit input.
- RST_VAL, 0: reset/init value of the shadow and active registers; width 8*NBYTES.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-low.
- init  in  1  synchronous clear of all state to RST_VAL, pointer to 0.
- load  in  1  write strobe for pload.
- seq  in  1  1 = sequential mode (lane = internal pointer); 0 = indexed (lane = load_sel); sampled with load.
- load_sel  in  PW  lane index in indexed mode; PW = $clog2(NBYTES).
- pload  in  8  write data.
- commit  in  1  explicit transfer of shadow to active.
- pout  out  8*NBYTES  active (committed) value.
- shadow  out  8*NBYTES  staging register contents.
- ptr  out  PW  current sequential pointer.
- pending  out  1  shadow holds uncommitted bytes.
- overrun  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset (rst==0 at a clock edge): pout=shadow=RST_VAL, ptr=0, pending=0, overrun=0.
- Priority each cycle: rst > init > load/commit. init has the same effect as reset.
- Write: on load=1, lane L = seq ? ptr : load_sel; shadow[8L+7:8L] <= pload next edge; pending <= 1.
- Indexed load with load_sel >= NBYTES: ignored; no state change, pending unchanged.
- Pointer:
  - Increments only on a sequential load; wraps NBYTES-1 -> 0.
  - Indexed loads do not move it.
  - Cleared to 0 on commit, init and reset.
- Commit trigger: commit=1, or (AUTO_COMMIT=1 and load=1 and L==NBYTES-1).
- Commit action: pout <= next-shadow, i.e. shadow with this cycle's write merged in. A simultaneous load and commit therefore includes the new byte. Also pending <= 0, ptr <= 0.
- Latency: pout reflects committed data one cycle after the commit edge. shadow reflects a write one cycle after load.
- commit with pending=0: pout reloaded from shadow (no visible change); legal.
- Shadow is not cleared by commit. Partial rewrites reuse the untouched lanes.
- load=0 and commit=0: all state holds.
- Reset or init mid-sequence discards partial shadow data; pout returns to RST_VAL.

Optional Feature:
- Macro: ILR_OVERRUN_EN.
- Enabled:
  - A per-lane written mask is cleared on commit/init/reset.
  - A load to a lane whose mask bit is already set sets overrun (sticky).
  - overrun clears only on init or reset.
  - The write still takes effect.
- Disabled: overrun tied to 0; no mask flops.

Decomposition:
- Shared package timer_pkg holds:
  - BYTE_W=8
  - the function lane_w(NBYTES) returning $clog2(NBYTES)
  - the typedef for lane index
  - the RST_VAL default constant
- One natural sub-module, ilr_byte_lane: a byte flop with write enable and init, instantiated NBYTES times for the shadow. The active register and control stay in the top level.

Test Plan:
- Reset: rst=0 for 2 cycles, NBYTES=4 -> pout=0, shadow=0, ptr=0, pending=0, overrun=0.
- Sequential auto-commit: seq=1, write 0x11,0x22,0x33,0x44 on consecutive cycles -> pout=0x00000000 through the third write; pout=0x44332211 one cycle after the 4th; pending=0, ptr=0.
- Indexed, no auto (AUTO_COMMIT=0): write lane2=0xAB, then lane0=0xCD -> pout unchanged, pending=1. Pulse commit -> pout=0x00AB00CD. Assert load lane1=0xEF together with commit -> pout=0x00ABEFCD.
- Pointer wrap and init: NBYTES=3, AUTO_COMMIT=0, four sequential writes 1,2,3,4 -> ptr sequence 1,2,0,1; shadow=0x030204. Then init=1 -> all state 0.
- Overrun (ILR_OVERRUN_EN defined): indexed write lane1 twice without commit -> overrun=1 after the second write and held through a commit; cleared by init. With the macro undefined -> overrun stays 0.
- Out-of-range and reset mid-sequence: NBYTES=3, load_sel=3 -> no change. Two sequential writes, then rst=0 -> shadow=0, ptr=0, pending=0.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared widths, lane-index helpers and reset default for the timer load registers
package timer_pkg;
  localparam int BYTE_W = 8;
  localparam int MAX_NBYTES = 8;
  localparam logic [BYTE_W*MAX_NBYTES-1:0] RST_VAL_DEF = '0;
  typedef logic [$clog2(MAX_NBYTES)-1:0] lane_t;
  function automatic int lane_w(input int nbytes);
    return $clog2(nbytes);
  endfunction
endpackage

// File: rtl/ilr_byte_lane.sv
// ilr_byte_lane: one shadow byte with write enable and synchronous clear to its reset value
module ilr_byte_lane
  import timer_pkg::*;
#(
  parameter logic [BYTE_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              we,
  input  logic [BYTE_W-1:0] d,
  output logic [BYTE_W-1:0] q
);
  always_ff @(posedge clk)
    if (!rst || init) q <= RST_VAL;
    else if (we) q <= d;
endmodule

// File: rtl/interleaved_load_reg.sv
// interleaved_load_reg: byte-wise shadow load with atomic commit to the active value
// ILR_OVERRUN_EN enables the sticky overrun flag for lanes rewritten before a commit
module interleaved_load_reg
  import timer_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter bit AUTO_COMMIT = 1,
  parameter logic [BYTE_W*NBYTES-1:0] RST_VAL = (BYTE_W*NBYTES)'(RST_VAL_DEF)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        init,
  input  logic                        load,
  input  logic                        seq,
  input  logic [lane_w(NBYTES)-1:0]   load_sel,
  input  logic [BYTE_W-1:0]           pload,
  input  logic                        commit,
  output logic [BYTE_W*NBYTES-1:0]    pout,
  output logic [BYTE_W*NBYTES-1:0]    shadow,
  output logic [lane_w(NBYTES)-1:0]   ptr,
  output logic                        pending,
  output logic                        overrun
);
  localparam int PW = lane_w(NBYTES);
  localparam int W = BYTE_W * NBYTES;
  logic [PW-1:0] lane;
  logic wr, cm;
  logic [NBYTES-1:0] we;
  logic [W-1:0] nxt;
  always_comb begin
    lane = seq ? ptr : load_sel;
    wr = load && (seq || 32'(load_sel) < NBYTES);
    cm = commit || (AUTO_COMMIT && wr && 32'(lane) == NBYTES - 1);
  end
  // nxt is the shadow with this cycle's write merged, so a commit captures it
  for (genvar b = 0; b < NBYTES; b++) begin : g_lane
    assign we[b] = wr && 32'(lane) == b;
    assign nxt[b*BYTE_W +: BYTE_W] = we[b] ? pload : shadow[b*BYTE_W +: BYTE_W];
    ilr_byte_lane #(.RST_VAL(RST_VAL[b*BYTE_W +: BYTE_W])) u_lane (
      .clk (clk),
      .rst (rst),
      .init(init),
      .we  (we[b]),
      .d   (pload),
      .q   (shadow[b*BYTE_W +: BYTE_W])
    );
  end
  always_ff @(posedge clk)
    if (!rst || init) pout <= RST_VAL;
    else if (cm) pout <= nxt;
  always_ff @(posedge clk)
    if (!rst || init || cm) ptr <= '0;
    else if (wr && seq) ptr <= 32'(ptr) == NBYTES - 1 ? '0 : ptr + 1'b1;
  always_ff @(posedge clk)
    if (!rst || init || cm) pending <= 1'b0;
    else if (wr) pending <= 1'b1;
`ifdef ILR_OVERRUN_EN
  logic [NBYTES-1:0] mask;
  always_ff @(posedge clk)
    if (!rst || init || cm) mask <= '0;
    else mask <= mask | we;
  always_ff @(posedge clk)
    if (!rst || init) overrun <= 1'b0;
    else if (|(we & mask)) overrun <= 1'b1;
`else
  assign overrun = 1'b0;
`endif
endmodule

// File: tb/tb_interleaved_load_reg.sv
// tb_interleaved_load_reg: directed vectors with a scoreboard queue checked by a separate monitor
module tb_interleaved_load_reg;
  import timer_pkg::*;
`ifdef ILR_OVERRUN_EN
  localparam logic OVR = 1'b1;
`else
  localparam logic OVR = 1'b0;
`endif
  typedef struct {
    string       nm;
    int          d;
    logic [31:0] po;
    logic [31:0] sh;
    logic [1:0]  pt;
    logic        pe;
    logic        ov;
  } exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  logic clk = 0, rst = 0;
  logic ld[3], sq[3], cm[3], in[3];
  logic [1:0] sel[3];
  logic [7:0] pl[3];
  logic [31:0] po0, sh0, po1, sh1;
  logic [23:0] po2, sh2;
  logic [1:0] pt0, pt1, pt2;
  logic pe0, pe1, pe2, ov0, ov1, ov2;
  always #5 clk = ~clk;
  interleaved_load_reg #(.NBYTES(4), .AUTO_COMMIT(1)) u_auto (
    .clk(clk), .rst(rst), .init(in[0]), .load(ld[0]), .seq(sq[0]), .load_sel(sel[0]),
    .pload(pl[0]), .commit(cm[0]), .pout(po0), .shadow(sh0), .ptr(pt0), .pending(pe0), .overrun(ov0));
  interleaved_load_reg #(.NBYTES(4), .AUTO_COMMIT(0)) u_man (
    .clk(clk), .rst(rst), .init(in[1]), .load(ld[1]), .seq(sq[1]), .load_sel(sel[1]),
    .pload(pl[1]), .commit(cm[1]), .pout(po1), .shadow(sh1), .ptr(pt1), .pending(pe1), .overrun(ov1));
  interleaved_load_reg #(.NBYTES(3), .AUTO_COMMIT(0)) u_three (
    .clk(clk), .rst(rst), .init(in[2]), .load(ld[2]), .seq(sq[2]), .load_sel(sel[2]),
    .pload(pl[2]), .commit(cm[2]), .pout(po2), .shadow(sh2), .ptr(pt2), .pending(pe2), .overrun(ov2));
  always @(negedge clk)
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] ap, as;
      logic [1:0] at;
      logic ae, ao;
      e = sb.pop_front();
      ap = e.d == 0 ? po0 : e.d == 1 ? po1 : {8'h00, po2};
      as = e.d == 0 ? sh0 : e.d == 1 ? sh1 : {8'h00, sh2};
      at = e.d == 0 ? pt0 : e.d == 1 ? pt1 : pt2;
      ae = e.d == 0 ? pe0 : e.d == 1 ? pe1 : pe2;
      ao = e.d == 0 ? ov0 : e.d == 1 ? ov1 : ov2;
      n_vec++;
      if ({ap, as, at, ae, ao} !== {e.po, e.sh, e.pt, e.pe, e.ov}) begin
        n_err++;
        $display("FAIL %s: got pout=%h shadow=%h ptr=%0d pending=%b overrun=%b, want pout=%h shadow=%h ptr=%0d pending=%b overrun=%b",
                 e.nm, ap, as, at, ae, ao, e.po, e.sh, e.pt, e.pe, e.ov);
      end
    end
  task automatic expect_st(input int d, input string nm, input logic [31:0] po, sh,
                           input logic [1:0] pt, input logic pe, ov);
    sb.push_back('{nm, d, po, sh, pt, pe, ov});
  endtask
  task automatic step(input int d, input logic l, s, input logic [1:0] ls, input logic [7:0] pd,
                      input logic c, i, input string nm, input logic [31:0] po, sh,
                      input logic [1:0] pt, input logic pe, ov);
    ld[d] = l; sq[d] = s; sel[d] = ls; pl[d] = pd; cm[d] = c; in[d] = i;
    @(posedge clk); #1;
    ld[d] = 0; cm[d] = 0; in[d] = 0;
    expect_st(d, nm, po, sh, pt, pe, ov);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 3; i++) begin
      ld[i] = 0; sq[i] = 0; cm[i] = 0; in[i] = 0; sel[i] = 0; pl[i] = 0;
    end
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) expect_st(i, "reset", 0, 0, 0, 0, 0);
    rst = 1;
    step(0, 1, 1, 0, 8'h11, 0, 0, "seq_w1", 32'h0, 32'h00000011, 1, 1, 0);
    step(0, 1, 1, 0, 8'h22, 0, 0, "seq_w2", 32'h0, 32'h00002211, 2, 1, 0);
    step(0, 1, 1, 0, 8'h33, 0, 0, "seq_w3", 32'h0, 32'h00332211, 3, 1, 0);
    step(0, 1, 1, 0, 8'h44, 0, 0, "seq_autocommit", 32'h44332211, 32'h44332211, 0, 0, 0);
    step(0, 0, 0, 0, 8'hFF, 0, 0, "hold", 32'h44332211, 32'h44332211, 0, 0, 0);
    step(0, 1, 1, 0, 8'h55, 0, 0, "partial_rewrite", 32'h44332211, 32'h44332255, 1, 1, 0);
    step(1, 1, 0, 2, 8'hAB, 0, 0, "idx_lane2", 32'h0, 32'h00AB0000, 0, 1, 0);
    step(1, 1, 0, 0, 8'hCD, 0, 0, "idx_lane0", 32'h0, 32'h00AB00CD, 0, 1, 0);
    step(1, 0, 0, 0, 8'h00, 1, 0, "commit", 32'h00AB00CD, 32'h00AB00CD, 0, 0, 0);
    step(1, 1, 0, 1, 8'hEF, 1, 0, "load_with_commit", 32'h00ABEFCD, 32'h00ABEFCD, 0, 0, 0);
    step(1, 1, 0, 3, 8'h99, 0, 0, "lane3_no_auto", 32'h00ABEFCD, 32'h99ABEFCD, 0, 1, 0);
    step(1, 1, 0, 1, 8'h12, 0, 0, "lane1_first", 32'h00ABEFCD, 32'h99AB12CD, 0, 1, 0);
    step(1, 1, 0, 1, 8'h34, 0, 0, "lane1_overrun", 32'h00ABEFCD, 32'h99AB34CD, 0, 1, OVR);
    step(1, 0, 0, 0, 8'h00, 1, 0, "overrun_held", 32'h99AB34CD, 32'h99AB34CD, 0, 0, OVR);
    step(1, 0, 0, 0, 8'h00, 0, 1, "init_clears", 32'h0, 32'h0, 0, 0, 0);
    step(2, 1, 1, 0, 8'h01, 0, 0, "n3_w1", 32'h0, 32'h000001, 1, 1, 0);
    step(2, 1, 1, 0, 8'h02, 0, 0, "n3_w2", 32'h0, 32'h000201, 2, 1, 0);
    step(2, 1, 1, 0, 8'h03, 0, 0, "n3_wrap", 32'h0, 32'h030201, 0, 1, 0);
    step(2, 1, 1, 0, 8'h04, 0, 0, "n3_w4", 32'h0, 32'h030204, 1, 1, OVR);
    step(2, 0, 0, 0, 8'h00, 0, 1, "n3_init", 32'h0, 32'h0, 0, 0, 0);
    step(2, 1, 0, 3, 8'h55, 0, 0, "n3_out_of_range", 32'h0, 32'h0, 0, 0, 0);
    step(2, 0, 0, 0, 8'h00, 1, 0, "n3_commit_empty", 32'h0, 32'h0, 0, 0, 0);
    step(2, 1, 1, 0, 8'h0A, 0, 0, "n3_seq_a", 32'h0, 32'h00000A, 1, 1, 0);
    step(2, 1, 1, 0, 8'h0B, 0, 0, "n3_seq_b", 32'h0, 32'h000B0A, 2, 1, 0);
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    expect_st(2, "n3_reset_mid", 0, 0, 0, 0, 0);
    expect_st(0, "auto_reset_mid", 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
